// File: rtl/spn_frame_sched_if.sv
// Stream bundle around spn_frame_sched: upstream source, spn in/out taps and framed output.
// master = sequencer side, slave = environment side.
interface spn_frame_sched_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned PARA       = 16
);
  logic [DATA_WIDTH-1:0] s_data            [PARA-1:0];
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] spn_input_stream  [PARA-1:0];
  logic                  spn_valid_in;
  logic [DATA_WIDTH-1:0] spn_output_stream [PARA-1:0];
  logic                  spn_valid_out;
  logic [DATA_WIDTH-1:0] m_data            [PARA-1:0];
  logic                  m_valid;
  logic                  m_first;
  logic                  m_last;

  modport master (
    input  s_data, s_valid, spn_output_stream, spn_valid_out,
    output s_ready, spn_input_stream, spn_valid_in, m_data, m_valid, m_first, m_last
  );

  modport slave (
    output s_data, s_valid, spn_output_stream, spn_valid_out,
    input  s_ready, spn_input_stream, spn_valid_in, m_data, m_valid, m_first, m_last
  );
endinterface

// File: rtl/spn_frame_sched.sv
// Frame sequencer feeding the 16-lane spn: preamble, contiguous beats, zero flush, output framing.
// Optional SPN_SCHED_STATS_EN adds busy-cycle and underrun-beat counters.
module spn_frame_sched #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned PARA         = 16,
  parameter int unsigned FRAME_LEN    = 16,
  parameter int unsigned GAP_CYCLES   = 0,
  parameter int unsigned FLUSH_CYCLES = 260,
  parameter int unsigned OUT_SKIP     = 1,
  parameter int unsigned FRAME_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_start_i,
  input  logic [FRAME_W-1:0] cmd_frames_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_underrun_o,
  output logic               err_timeout_o,
`ifdef SPN_SCHED_STATS_EN
  output logic [31:0]        stat_cycles_o,
  output logic [15:0]        stat_underruns_o,
`endif
  spn_frame_sched_if.master  bus
);

  localparam int unsigned CNT_W  = FRAME_W + $clog2(FRAME_LEN);
  localparam int unsigned BEAT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int unsigned SKIP_W = (OUT_SKIP > 0) ? $clog2(OUT_SKIP + 1) : 1;

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_STREAM, S_GAP, S_FLUSH, S_WAIT_OUT} state_e;

  state_e                state_q, state_d;
  logic [FRAME_W-1:0]    frames_left_q, frames_left_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [31:0]           phase_q, phase_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_u_q, err_u_d;
  logic                  err_t_q, err_t_d;
  logic                  vin_q, vin_d;
  logic [DATA_WIDTH-1:0] din_q [PARA-1:0];
  logic [DATA_WIDTH-1:0] din_d [PARA-1:0];
  logic [CNT_W-1:0]      total_q, total_d;
  logic [CNT_W-1:0]      out_cnt_q, out_cnt_d;
  logic [BEAT_W-1:0]     out_idx_q, out_idx_d;
  logic [SKIP_W-1:0]     skip_q, skip_d;
  logic                  vout_prev_q;
  logic [SKIP_W-1:0]     skip_cur;
  logic                  count_ok;
  logic                  start_ok;
  logic                  out_complete;

  assign start_ok     = cmd_start_i && (state_q == S_IDLE) && !done_q;
  assign out_complete = (out_cnt_q == total_q);

  always_comb begin
    state_d       = state_q;
    frames_left_d = frames_left_q;
    beat_d        = beat_q;
    phase_d       = phase_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    err_u_d       = err_u_q;
    err_t_d       = err_t_q;
    vin_d         = 1'b0;
    din_d         = '{default: '0};
    total_d       = total_q;
    out_cnt_d     = out_cnt_q;
    out_idx_d     = out_idx_q;
    skip_d        = skip_q;
    skip_cur      = skip_q;
    count_ok      = 1'b0;

    // With gaps the spn output drops between frames, so every rise carries a fresh preamble.
    if (GAP_CYCLES > 0 && bus.spn_valid_out && !vout_prev_q)
      skip_cur = SKIP_W'(OUT_SKIP);

    // Beats emerging after done belong to no command and are never counted.
    if (bus.spn_valid_out) begin
      if (skip_cur != '0) begin
        skip_d = skip_cur - SKIP_W'(1);
      end else if (busy_q && (out_cnt_q < total_q)) begin
        count_ok  = 1'b1;
        out_cnt_d = out_cnt_q + CNT_W'(1);
        out_idx_d = (out_idx_q == BEAT_W'(FRAME_LEN - 1)) ? '0 : out_idx_q + BEAT_W'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          if (cmd_frames_i != '0) begin
            frames_left_d = cmd_frames_i;
            total_d       = CNT_W'(cmd_frames_i) * CNT_W'(FRAME_LEN);
            err_u_d       = 1'b0;
            err_t_d       = 1'b0;
            busy_d        = 1'b1;
            out_cnt_d     = '0;
            out_idx_d     = '0;
            skip_d        = SKIP_W'(OUT_SKIP);
            state_d       = S_PRE;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_PRE: begin
        vin_d   = 1'b1;
        beat_d  = '0;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        vin_d = 1'b1;
        if (bus.s_valid) din_d = bus.s_data;
        else             err_u_d = 1'b1;
        if (beat_q == BEAT_W'(FRAME_LEN - 1)) begin
          beat_d        = '0;
          phase_d       = '0;
          frames_left_d = frames_left_q - FRAME_W'(1);
          if (frames_left_q == FRAME_W'(1)) state_d = S_FLUSH;
          else if (GAP_CYCLES > 0)          state_d = S_GAP;
          else                              state_d = S_STREAM;
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end
      S_GAP: begin
        if (phase_q == 32'(GAP_CYCLES - 1)) begin
          phase_d = '0;
          state_d = S_PRE;
        end else begin
          phase_d = phase_q + 32'd1;
        end
      end
      S_FLUSH: begin
        vin_d = 1'b1;
        if (phase_q == 32'(FLUSH_CYCLES - 1)) begin
          phase_d = '0;
          if (out_complete) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_WAIT_OUT;
          end
        end else begin
          phase_d = phase_q + 32'd1;
        end
      end
      S_WAIT_OUT: begin
        if (out_complete) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (phase_q == 32'(FLUSH_CYCLES - 1)) begin
          err_t_d = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          phase_d = phase_q + 32'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      frames_left_q <= '0;
      beat_q        <= '0;
      phase_q       <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_u_q       <= 1'b0;
      err_t_q       <= 1'b0;
      vin_q         <= 1'b0;
      din_q         <= '{default: '0};
      total_q       <= '0;
      out_cnt_q     <= '0;
      out_idx_q     <= '0;
      skip_q        <= '0;
      vout_prev_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      frames_left_q <= frames_left_d;
      beat_q        <= beat_d;
      phase_q       <= phase_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_u_q       <= err_u_d;
      err_t_q       <= err_t_d;
      vin_q         <= vin_d;
      din_q         <= din_d;
      total_q       <= total_d;
      out_cnt_q     <= out_cnt_d;
      out_idx_q     <= out_idx_d;
      skip_q        <= skip_d;
      vout_prev_q   <= bus.spn_valid_out;
    end
  end

`ifdef SPN_SCHED_STATS_EN
  logic [31:0] stat_cyc_q;
  logic [15:0] stat_und_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_cyc_q <= '0;
      stat_und_q <= '0;
    end else if (start_ok && (cmd_frames_i != '0)) begin
      stat_cyc_q <= '0;
      stat_und_q <= '0;
    end else begin
      if (busy_q && (stat_cyc_q != '1)) stat_cyc_q <= stat_cyc_q + 32'd1;
      if ((state_q == S_STREAM) && !bus.s_valid && (stat_und_q != '1))
        stat_und_q <= stat_und_q + 16'd1;
    end
  end

  assign stat_cycles_o    = stat_cyc_q;
  assign stat_underruns_o = stat_und_q;
`endif

  assign busy_o               = busy_q;
  assign done_o               = done_q;
  assign err_underrun_o       = err_u_q;
  assign err_timeout_o        = err_t_q;
  assign bus.s_ready          = (state_q == S_STREAM);
  assign bus.spn_valid_in     = vin_q;
  assign bus.spn_input_stream = din_q;
  assign bus.m_data           = bus.spn_output_stream;
  assign bus.m_valid          = count_ok;
  assign bus.m_first          = count_ok && (out_idx_q == '0);
  assign bus.m_last           = count_ok && (out_idx_q == BEAT_W'(FRAME_LEN - 1));

endmodule

// File: tb/tb_spn_frame_sched.sv
// Scoreboard bench for spn_frame_sched: one instance without gaps, one with GAP_CYCLES=4,
// sharing a delay-line spn model fed from whichever instance is selected.
module tb_spn_frame_sched;
  localparam int unsigned DW = 32;
  localparam int unsigned P  = 16;
  localparam int unsigned FL = 16;

  typedef struct {
    logic [63:0] d;
    logic        f;
    logic        l;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_start;
  logic [15:0]   cmd_frames;
  logic          sel;
  logic          s_valid;
  logic [DW-1:0] s_data [P-1:0];
  logic          mo_v;
  logic [DW-1:0] mo_d [P-1:0];
  int unsigned   lat;

  logic busy0, done0, eu0, et0, busy1, done1, eu1, et1;
`ifdef SPN_SCHED_STATS_EN
  logic [31:0] sc0, sc1;
  logic [15:0] su0, su1;
`endif

  spn_frame_sched_if #(.DATA_WIDTH(DW), .PARA(P)) bus0 ();
  spn_frame_sched_if #(.DATA_WIDTH(DW), .PARA(P)) bus1 ();

  assign bus0.s_data = s_data;  assign bus1.s_data = s_data;
  assign bus0.s_valid = s_valid; assign bus1.s_valid = s_valid;
  assign bus0.spn_output_stream = mo_d; assign bus1.spn_output_stream = mo_d;
  assign bus0.spn_valid_out = mo_v; assign bus1.spn_valid_out = mo_v;

  spn_frame_sched #(.DATA_WIDTH(DW), .PARA(P), .FRAME_LEN(FL), .GAP_CYCLES(0),
                    .FLUSH_CYCLES(260), .OUT_SKIP(1), .FRAME_W(16)) u_dut (
    .clk(clk), .rst(rst), .cmd_start_i(cmd_start && !sel), .cmd_frames_i(cmd_frames),
    .busy_o(busy0), .done_o(done0), .err_underrun_o(eu0), .err_timeout_o(et0),
`ifdef SPN_SCHED_STATS_EN
    .stat_cycles_o(sc0), .stat_underruns_o(su0),
`endif
    .bus(bus0.master)
  );

  spn_frame_sched #(.DATA_WIDTH(DW), .PARA(P), .FRAME_LEN(FL), .GAP_CYCLES(4),
                    .FLUSH_CYCLES(260), .OUT_SKIP(1), .FRAME_W(16)) u_dut_gap (
    .clk(clk), .rst(rst), .cmd_start_i(cmd_start && sel), .cmd_frames_i(cmd_frames),
    .busy_o(busy1), .done_o(done1), .err_underrun_o(eu1), .err_timeout_o(et1),
`ifdef SPN_SCHED_STATS_EN
    .stat_cycles_o(sc1), .stat_underruns_o(su1),
`endif
    .bus(bus1.master)
  );

  always #5 clk = ~clk;

  logic          o_busy, o_done, o_eu, o_et, o_ready, o_vin, o_mv, o_mf, o_ml;
  logic [63:0]   o_in, o_md;
  logic [DW-1:0] o_din [P-1:0];

  always_comb begin
    o_busy  = sel ? busy1 : busy0;
    o_done  = sel ? done1 : done0;
    o_eu    = sel ? eu1 : eu0;
    o_et    = sel ? et1 : et0;
    o_ready = sel ? bus1.s_ready : bus0.s_ready;
    o_vin   = sel ? bus1.spn_valid_in : bus0.spn_valid_in;
    o_mv    = sel ? bus1.m_valid : bus0.m_valid;
    o_mf    = sel ? bus1.m_first : bus0.m_first;
    o_ml    = sel ? bus1.m_last : bus0.m_last;
    o_in    = sel ? {bus1.spn_input_stream[P-1], bus1.spn_input_stream[0]}
                  : {bus0.spn_input_stream[P-1], bus0.spn_input_stream[0]};
    o_md    = sel ? {bus1.m_data[P-1], bus1.m_data[0]} : {bus0.m_data[P-1], bus0.m_data[0]};
    if (sel) o_din = bus1.spn_input_stream;
    else     o_din = bus0.spn_input_stream;
  end

  // spn model: pure delay line of (valid_in, data); the zero preamble re-emerges first.
  logic          hv [1024];
  logic [DW-1:0] hd [1024][P-1:0];
  logic [9:0]    wp;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) hv[i] <= 1'b0;
      wp   <= '0;
      mo_v <= 1'b0;
    end else begin
      hv[wp] <= o_vin;
      hd[wp] <= o_din;
      wp     <= wp + 10'd1;
      mo_v   <= hv[wp - 10'(lat)];
      mo_d   <= hd[wp - 10'(lat)];
    end
  end

  int   n_total = 0, n_bad = 0;
  int   n_done, n_busy, n_vin, n_ready, n_mbeats, zero_run, beat_i, drop_lo, drop_hi;
  logic prev_vin = 1'b0, prev_ready = 1'b0, seen_vin;
  exp_t sb [$];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    n_done = 0; n_busy = 0; n_vin = 0; n_ready = 0; n_mbeats = 0;
    zero_run = 0; seen_vin = 1'b0; beat_i = 0;
    sb.delete();
  endtask

  initial begin : mon_drv
    exp_t e;
    clr();
    forever begin
      @(negedge clk);
      if (o_mv) begin
        n_mbeats++;
        if (sb.size() == 0) check_val("m_extra", 64'd1, 64'd0);
        else begin
          e = sb.pop_front();
          check_val("m_data", o_md, e.d);
          check_val("m_first", {63'd0, o_mf}, {63'd0, e.f});
          check_val("m_last", {63'd0, o_ml}, {63'd0, e.l});
        end
      end
      if (o_done)  n_done++;
      if (o_busy)  n_busy++;
      if (o_vin)   n_vin++;
      if (o_ready) n_ready++;
      if (o_ready && !prev_ready) begin
        check_val("pre_vin", {62'd0, prev_vin, o_vin}, 64'd1);
        check_val("pre_zero", o_in, 64'd0);
      end
      if (o_vin && !prev_vin) begin
        if (seen_vin && sel) check_val("gap_len", 64'(zero_run), 64'd4);
        zero_run = 0;
      end else if (!o_vin && seen_vin) begin
        zero_run++;
      end
      if (o_vin) seen_vin = 1'b1;
      prev_vin   = o_vin;
      prev_ready = o_ready;
      if (o_ready) begin
        for (int k = 0; k < P; k++) s_data[k] = $urandom;
        s_valid = !(beat_i >= drop_lo && beat_i < drop_hi);
        e.d = s_valid ? {s_data[P-1], s_data[0]} : 64'd0;
        e.f = (beat_i % FL) == 0;
        e.l = (beat_i % FL) == FL - 1;
        sb.push_back(e);
        beat_i++;
      end else begin
        s_valid = 1'b0;
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_cmd(input logic [15:0] f, input int budget);
    clr();
    @(negedge clk);
    cmd_frames = f;
    cmd_start  = 1'b1;
    @(negedge clk);
    cmd_start  = 1'b0;
    for (int i = 0; i < budget && n_done == 0; i++) @(negedge clk);
    if (n_done == 0) check_val("done_wait", 64'd0, 64'd1);
    repeat (40) @(negedge clk);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    rst = 1'b1; cmd_start = 1'b0; cmd_frames = '0; sel = 1'b0; lat = 19;
    drop_lo = 0; drop_hi = 0; s_valid = 1'b0;
    for (int k = 0; k < P; k++) s_data[k] = '0;
    repeat (2) @(negedge clk);
    #1;
    check_val("rst_busy", {63'd0, o_busy}, 64'd0);
    check_val("rst_done", {63'd0, o_done}, 64'd0);
    check_val("rst_err", {62'd0, o_eu, o_et}, 64'd0);
    check_val("rst_ready", {63'd0, o_ready}, 64'd0);
    check_val("rst_vin", {63'd0, o_vin}, 64'd0);
    check_val("rst_mout", {61'd0, o_mv, o_mf, o_ml}, 64'd0);
    check_val("rst_data", o_in, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // underrun: three dropped slots in the middle of a single frame
    drop_lo = 5; drop_hi = 8;
    run_cmd(16'd1, 400);
    check_val("ur_err_u", {63'd0, o_eu}, 64'd1);
    check_val("ur_err_t", {63'd0, o_et}, 64'd0);
    check_val("ur_done", 64'(n_done), 64'd1);
    check_val("ur_ready", 64'(n_ready), 64'd16);
    check_val("ur_mbeats", 64'(n_mbeats), 64'd16);
    check_val("ur_busy", 64'(n_busy), 64'd277);
`ifdef SPN_SCHED_STATS_EN
    check_val("ur_stat_und", 64'(su0), 64'd3);
`endif
    drop_lo = 0; drop_hi = 0;

    // clean two-frame run; also shows the sticky underrun cleared by the new start
    run_cmd(16'd2, 600);
    check_val("c_err_u", {63'd0, o_eu}, 64'd0);
    check_val("c_err_t", {63'd0, o_et}, 64'd0);
    check_val("c_done", 64'(n_done), 64'd1);
    check_val("c_ready", 64'(n_ready), 64'd32);
    check_val("c_vin", 64'(n_vin), 64'd293);
    check_val("c_mbeats", 64'(n_mbeats), 64'd32);
    check_val("c_busy", 64'(n_busy), 64'd293);
    check_val("c_sb_left", 64'(sb.size()), 64'd0);
`ifdef SPN_SCHED_STATS_EN
    check_val("c_stat_cyc", 64'(sc0), 64'd293);
    check_val("c_stat_und", 64'(su0), 64'd0);
`endif

    // zero frames: done one cycle later, nothing else moves
    clr();
    @(negedge clk);
    cmd_frames = 16'd0;
    cmd_start  = 1'b1;
    @(negedge clk);
    cmd_start  = 1'b0;
    #1;
    check_val("z_done_now", {63'd0, o_done}, 64'd1);
    repeat (20) @(negedge clk);
    check_val("z_done_cnt", 64'(n_done), 64'd1);
    check_val("z_busy", 64'(n_busy), 64'd0);
    check_val("z_vin", 64'(n_vin), 64'd0);

    // gap instance: three preamble+16-beat bursts separated by 4 idle slots
    sel = 1'b1;
    run_cmd(16'd3, 800);
    check_val("g_done", 64'(n_done), 64'd1);
    check_val("g_ready", 64'(n_ready), 64'd48);
    check_val("g_vin", 64'(n_vin), 64'd311);
    check_val("g_mbeats", 64'(n_mbeats), 64'd48);
    check_val("g_err", {62'd0, o_eu, o_et}, 64'd0);
    check_val("g_sb_left", 64'(sb.size()), 64'd0);
    sel = 1'b0;

    // spn latency beyond flush plus wait window
    lat = 599;
    do_reset();
    run_cmd(16'd1, 800);
    check_val("t_err_t", {63'd0, o_et}, 64'd1);
    check_val("t_err_u", {63'd0, o_eu}, 64'd0);
    check_val("t_done", 64'(n_done), 64'd1);
    check_val("t_busy", 64'(n_busy), 64'd537);
    repeat (700) @(negedge clk);
    check_val("t_mbeats", 64'(n_mbeats), 64'd0);

    // async reset in the middle of beat 7, then a clean single frame
    lat = 19;
    do_reset();
    clr();
    @(negedge clk);
    cmd_frames = 16'd2;
    cmd_start  = 1'b1;
    @(negedge clk);
    cmd_start  = 1'b0;
    for (int i = 0; i < 10 && !o_ready; i++) @(negedge clk);
    check_val("r_stream", {63'd0, o_ready}, 64'd1);
    repeat (7) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_val("r_busy", {63'd0, o_busy}, 64'd0);
    check_val("r_done", {63'd0, o_done}, 64'd0);
    check_val("r_ready", {63'd0, o_ready}, 64'd0);
    check_val("r_vin", {63'd0, o_vin}, 64'd0);
    check_val("r_data", o_in, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_cmd(16'd1, 400);
    check_val("r2_done", 64'(n_done), 64'd1);
    check_val("r2_ready", 64'(n_ready), 64'd16);
    check_val("r2_mbeats", 64'(n_mbeats), 64'd16);
    check_val("r2_err", {62'd0, o_eu, o_et}, 64'd0);
    check_val("r2_sb_left", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
